// File: rtl/clk_en_gen.sv
// Multi-channel clock-enable generator: after a lock delay, each channel emits a
// divided clock and a one-cycle enable pulse per divided period.
`timescale 1ns/1ps
module clk_en_gen #(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = 16,
  parameter int LOCK_CYCLES = 16,
  parameter int DEF_DIV     = 2
) (
  input  logic                    inclk0,
  input  logic                    areset,
  input  logic                    cfg_load,
  input  logic [NUM_CH*CNT_W-1:0] div_in,
  input  logic [NUM_CH*CNT_W-1:0] phase_in,
  output logic [NUM_CH-1:0]       clk_out,
  output logic [NUM_CH-1:0]       ce,
  output logic                    locked
);

  localparam int LCK_W = (LOCK_CYCLES > 2) ? $clog2(LOCK_CYCLES) : 1;
  localparam logic [LCK_W-1:0] LOCK_LAST = LCK_W'(LOCK_CYCLES - 1);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  typedef enum logic {WAIT, RUN} state_t;

  state_t            state;
  logic [LCK_W-1:0]  lock_cnt;
  logic [CNT_W-1:0]  div_r   [NUM_CH];
  logic [CNT_W-1:0]  phase_r [NUM_CH];
  logic [CNT_W-1:0]  cnt     [NUM_CH];
  logic [CNT_W-1:0]  cnt_inc [NUM_CH];
  logic [CNT_W-1:0]  half    [NUM_CH];
  logic [CNT_W-1:0]  start   [NUM_CH];
  logic [NUM_CH-1:0] wrap;

  // A start offset at or beyond the ratio cannot be reached by the counter, so it folds to 0.
  function automatic logic [CNT_W-1:0] start_phase(input logic [CNT_W-1:0] ph,
                                                   input logic [CNT_W-1:0] dv);
    return (ph < dv) ? ph : '0;
  endfunction

  always_comb begin
    wrap = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      cnt_inc[k] = cnt[k] + ONE;
      half[k]    = div_r[k] >> 1;
      start[k]   = start_phase(phase_r[k], div_r[k]);
      wrap[k]    = (div_r[k] != '0) && (cnt[k] == div_r[k] - ONE);
    end
  end

  always_ff @(posedge inclk0 or posedge areset) begin
    if (areset) begin
      state    <= WAIT;
      lock_cnt <= '0;
      locked   <= 1'b0;
      clk_out  <= '0;
      ce       <= '0;
      for (int k = 0; k < NUM_CH; k++) begin
        cnt[k]     <= '0;
        div_r[k]   <= CNT_W'(DEF_DIV);
        phase_r[k] <= '0;
      end
    end else if (cfg_load) begin
      state    <= WAIT;
      lock_cnt <= '0;
      locked   <= 1'b0;
      clk_out  <= '0;
      ce       <= '0;
      for (int k = 0; k < NUM_CH; k++) begin
        cnt[k]     <= '0;
        div_r[k]   <= div_in[k*CNT_W +: CNT_W];
        phase_r[k] <= phase_in[k*CNT_W +: CNT_W];
      end
    end else begin
      case (state)
        WAIT: begin
          if (lock_cnt == LOCK_LAST) begin
            state    <= RUN;
            locked   <= 1'b1;
            lock_cnt <= '0;
            // Outputs on the lock edge already reflect the start phase.
            for (int k = 0; k < NUM_CH; k++) begin
              cnt[k]     <= start[k];
              ce[k]      <= (div_r[k] == ONE);
              clk_out[k] <= (start[k] < half[k]);
            end
          end else begin
            lock_cnt <= lock_cnt + 1'b1;
          end
        end
        RUN: begin
          for (int k = 0; k < NUM_CH; k++) begin
            if (div_r[k] == '0) begin
              cnt[k]     <= '0;
              ce[k]      <= 1'b0;
              clk_out[k] <= 1'b0;
            end else if (wrap[k]) begin
              cnt[k]     <= '0;
              ce[k]      <= 1'b1;
              clk_out[k] <= (half[k] != '0);
            end else begin
              cnt[k]     <= cnt_inc[k];
              ce[k]      <= 1'b0;
              clk_out[k] <= (cnt_inc[k] < half[k]);
            end
          end
        end
        default: state <= WAIT;
      endcase
    end
  end

endmodule

// File: tb/tb_clk_en_gen.sv
// Bench for clk_en_gen: random and directed configurations against a time-since-lock model.
`timescale 1ns/1ps
module tb_clk_en_gen;
  localparam int NUM_CH = 4;
  localparam int CNT_W = 16;
  localparam int LOCK_CYCLES = 16;
  localparam int DEF_DIV = 2;

  logic                    inclk0 = 1'b0;
  logic                    areset = 1'b1;
  logic                    cfg_load = 1'b0;
  logic [NUM_CH*CNT_W-1:0] div_in = '0;
  logic [NUM_CH*CNT_W-1:0] phase_in = '0;
  logic [NUM_CH-1:0]       clk_out;
  logic [NUM_CH-1:0]       ce;
  logic                    locked;

  int errors = 0;
  int checks = 0;

  clk_en_gen #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .LOCK_CYCLES(LOCK_CYCLES), .DEF_DIV(DEF_DIV)) dut (
    .inclk0(inclk0), .areset(areset), .cfg_load(cfg_load), .div_in(div_in),
    .phase_in(phase_in), .clk_out(clk_out), .ce(ce), .locked(locked));

  always #5 inclk0 = ~inclk0;

  // Model: outputs follow from the edges elapsed since lock, n, via modular arithmetic.
  longint m_div [NUM_CH] = '{default: DEF_DIV};
  longint m_ph  [NUM_CH] = '{default: 0};
  int     m_wait = 0;
  bit     m_run = 1'b0;
  longint m_n = 0;

  always @(posedge inclk0 or posedge areset) begin
    if (areset) begin
      m_wait = 0; m_run = 1'b0; m_n = 0;
      for (int k = 0; k < NUM_CH; k++) begin m_div[k] = DEF_DIV; m_ph[k] = 0; end
    end else if (cfg_load) begin
      m_wait = 0; m_run = 1'b0;
      for (int k = 0; k < NUM_CH; k++) begin
        m_div[k] = longint'(div_in[k*CNT_W +: CNT_W]);
        m_ph[k]  = longint'(phase_in[k*CNT_W +: CNT_W]);
      end
    end else if (!m_run) begin
      m_wait++;
      if (m_wait == LOCK_CYCLES) begin m_run = 1'b1; m_n = 0; end
    end else begin
      m_n++;
    end
  end

  function automatic void model_out(output logic [NUM_CH-1:0] eclk, output logic [NUM_CH-1:0] ece);
    longint d, s, c;
    eclk = '0; ece = '0;
    if (m_run) begin
      for (int k = 0; k < NUM_CH; k++) begin
        d = m_div[k];
        if (d == 1) ece[k] = 1'b1;
        else if (d >= 2) begin
          s = (m_ph[k] < d) ? m_ph[k] : 0;
          c = (s + m_n) % d;
          eclk[k] = (c < d / 2);
          ece[k]  = (m_n > 0) && (c == 0);
        end
      end
    end
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  always @(negedge inclk0) begin
    logic [NUM_CH-1:0] eclk, ece;
    model_out(eclk, ece);
    chk("locked", longint'(locked), longint'(m_run));
    chk("clk_out", longint'(clk_out), longint'(eclk));
    chk("ce", longint'(ce), longint'(ece));
  end

  int cnt_ce [NUM_CH];
  int cnt_hi [NUM_CH];
  int first  [NUM_CH];

  function automatic logic [NUM_CH*CNT_W-1:0] pk(input logic [CNT_W-1:0] a, input logic [CNT_W-1:0] b,
                                                  input logic [CNT_W-1:0] c, input logic [CNT_W-1:0] d);
    return {d, c, b, a};
  endfunction

  task automatic tick(input int n);
    repeat (n) begin @(posedge inclk0); #1; end
  endtask

  task automatic do_load(input logic [NUM_CH*CNT_W-1:0] d, input logic [NUM_CH*CNT_W-1:0] p);
    div_in = d; phase_in = p; cfg_load = 1'b1;
    @(posedge inclk0); #1;
    cfg_load = 1'b0;
  endtask

  task automatic wait_lock(input string name);
    int e = 0;
    while (!locked && e < 200) begin @(posedge inclk0); #1; e++; end
    chk(name, e, LOCK_CYCLES);
  endtask

  task automatic measure(input int cyc);
    for (int k = 0; k < NUM_CH; k++) begin cnt_ce[k] = 0; cnt_hi[k] = 0; end
    repeat (cyc) begin
      for (int k = 0; k < NUM_CH; k++) begin
        cnt_ce[k] += int'(ce[k]);
        cnt_hi[k] += int'(clk_out[k]);
      end
      @(posedge inclk0); #1;
    end
  endtask

  task automatic find_first(input int limit);
    for (int k = 0; k < NUM_CH; k++) first[k] = -1;
    for (int i = 0; i < limit; i++) begin
      for (int k = 0; k < NUM_CH; k++) if (ce[k] && first[k] < 0) first[k] = i;
      @(posedge inclk0); #1;
    end
  endtask

  initial begin
    int gap;
    // Power-up with a load attempt during reset, which must be ignored.
    tick(50);
    div_in = pk(5, 5, 5, 5); cfg_load = 1'b1;
    tick(5);
    cfg_load = 1'b0;
    tick(45);
    chk("reset_locked", locked, 0);
    chk("reset_clk_out", clk_out, 0);
    chk("reset_ce", ce, 0);
    areset = 1'b0;
    wait_lock("powerup_lock_edges");
    chk("pu_n0_clk", clk_out, 4'hF);
    chk("pu_n0_ce", ce, 4'h0);
    tick(1);
    chk("pu_n1_clk", clk_out, 4'h0);
    chk("pu_n1_ce", ce, 4'h0);
    tick(1);
    chk("pu_n2_clk", clk_out, 4'hF);
    chk("pu_n2_ce", ce, 4'hF);
    measure(8);
    chk("pu_ce_count_ch0", cnt_ce[0], 4);
    chk("pu_ce_count_ch3", cnt_ce[3], 4);

    // Divide sweep {5,4,1,0}.
    do_load(pk(5, 4, 1, 0), '0);
    chk("sweep_unlock", locked, 0);
    wait_lock("sweep_lock_edges");
    tick(1);
    measure(20);
    chk("sweep_ce_ch0", cnt_ce[0], 4);
    chk("sweep_hi_ch0", cnt_hi[0], 8);
    chk("sweep_ce_ch1", cnt_ce[1], 5);
    chk("sweep_hi_ch1", cnt_hi[1], 10);
    chk("sweep_ce_ch2", cnt_ce[2], 20);
    chk("sweep_hi_ch2", cnt_hi[2], 0);
    chk("sweep_ce_ch3", cnt_ce[3], 0);
    chk("sweep_hi_ch3", cnt_hi[3], 0);

    // Phase offsets.
    do_load(pk(8, 8, 8, 8), pk(0, 2, 4, 9));
    wait_lock("phase_lock_edges");
    find_first(12);
    chk("phase_first_ch0", first[0], 8);
    chk("phase_lead_ch1", first[0] - first[1], 2);
    chk("phase_lead_ch2", first[0] - first[2], 4);
    chk("phase_ch3_aligned", first[3], first[0]);

    // Back-to-back loads: the second one restarts the lock count and wins.
    do_load(pk(6, 6, 6, 6), '0);
    tick(10);
    do_load(pk(3, 3, 3, 3), '0);
    tick(3);
    do_load(pk(5, 3, 7, 1), pk(1, 0, 2, 0));
    wait_lock("b2b_lock_edges");
    tick(1);
    measure(15);
    chk("b2b_ce_ch0", cnt_ce[0], 3);
    chk("b2b_ce_ch1", cnt_ce[1], 5);
    chk("b2b_ce_ch2", cnt_ce[2], 2);
    chk("b2b_ce_ch3", cnt_ce[3], 15);

    // Asynchronous reset pulse mid-run.
    do_load(pk(7, 7, 7, 7), '0);
    wait_lock("d7_lock_edges");
    tick(7);
    chk("d7_pre_clk", clk_out, 4'hF);
    chk("d7_pre_ce", ce, 4'hF);
    #2 areset = 1'b1;
    #0.5;
    chk("rst_async_locked", locked, 0);
    chk("rst_async_clk", clk_out, 0);
    chk("rst_async_ce", ce, 0);
    #0.5 areset = 1'b0;
    wait_lock("rst_relock_edges");
    tick(2);
    chk("rst_default_ce", ce, 4'hF);

    // Randomized configurations, reload timing and occasional reset pulses.
    for (int r = 0; r < 12; r++) begin
      do_load(pk(16'($urandom_range(0, 12)), 16'($urandom_range(0, 12)),
                 16'($urandom_range(0, 12)), 16'($urandom_range(0, 12))),
              pk(16'($urandom_range(0, 15)), 16'($urandom_range(0, 15)),
                 16'($urandom_range(0, 15)), 16'($urandom_range(0, 15))));
      tick($urandom_range(3, 60));
      if ($urandom_range(0, 3) == 0) begin
        #($urandom_range(1, 2)) areset = 1'b1;
        #1 areset = 1'b0;
        tick($urandom_range(20, 40));
      end
    end

    // Wide count: ratio 65535 with the start placed just before the wrap.
    do_load(pk(16'hFFFF, 16'hFFFF, 0, 1), pk(16'hFFFA, 0, 0, 0));
    wait_lock("wide_lock_edges");
    find_first(8);
    chk("wide_first_ch0", first[0], 5);
    gap = 0;
    while (!ce[0] && gap < 70000) begin
      for (int k = 0; k < NUM_CH; k++) if (ce[k] && first[k] < 0) first[k] = gap + 8;
      @(posedge inclk0); #1; gap++;
    end
    chk("wide_gap_ch0", gap + 8 - first[0], 65535);
    chk("wide_first_ch1", first[1], 65535);
    tick(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/clk_en_gen.md
CLK_EN_GEN -- requirements
Module: clk_en_gen

Interface
REQ-001 Parameter NUM_CH, default 4, number of output channels (1..8).
REQ-002 Parameter CNT_W, default 16, width of each per-channel divide and phase field.
REQ-003 Parameter LOCK_CYCLES, default 16, number of inclk0 cycles from reset release or config load to lock (>=2).
REQ-004 Parameter DEF_DIV, default 2, reset value of every channel divide ratio.
REQ-005 inclk0  input  1  sole clock; all logic on its rising edge.
REQ-006 areset  input  1  reset, asynchronous, active-high.
REQ-007 cfg_load  input  1  single-cycle strobe; captures div_in/phase_in.
REQ-008 div_in  input  NUM_CH*CNT_W  per-channel divide ratio; channel k is at bits [k*CNT_W +: CNT_W].
REQ-009 phase_in  input  NUM_CH*CNT_W  per-channel start offset; same packing as div_in.
REQ-010 clk_out  output  NUM_CH  registered divided clocks.
REQ-011 ce  output  NUM_CH  registered one-cycle clock-enable pulses, one per divided period.
REQ-012 locked  output  1  high while the outputs are valid.

Function
REQ-013 The block SHALL implement the FSM states WAIT and RUN; it SHALL enter WAIT on reset.
REQ-014 In WAIT, lock_cnt SHALL increment each cycle. When lock_cnt == LOCK_CYCLES-1, the next edge SHALL move to RUN, set locked=1 and load each channel counter cnt[k] with its start phase.
REQ-015 locked SHALL rise on the LOCK_CYCLES-th rising edge after areset deasserts; clk_out and ce SHALL stay 0 throughout WAIT.
REQ-016 cfg_load SHALL copy div_in/phase_in into shadow registers div_r/phase_r on the same edge. Channels SHALL use only the shadow values.
REQ-017 cfg_load in RUN SHALL, on the same edge, enter WAIT, clear locked, clk_out, ce and lock_cnt; relock then follows REQ-014.
REQ-018 cfg_load in WAIT SHALL capture the new configuration and restart lock_cnt at 0.
REQ-019 Start phase: start = phase_r[k] if phase_r[k] < div_r[k], else 0.
REQ-020 In RUN with div_r[k] >= 2, cnt[k] SHALL count 0..div_r[k]-1 and wrap to 0.
REQ-021 In RUN with div_r[k] >= 2, ce[k] SHALL be high for exactly the cycle after cnt[k] == div_r[k]-1, i.e. one pulse per div_r[k] cycles.
REQ-022 In RUN with div_r[k] >= 2, clk_out[k] SHALL be high while the registered count is < (div_r[k]>>1) and low otherwise; odd ratios give a shorter high phase.
REQ-023 div_r[k] == 1: ce[k] SHALL be constantly 1 in RUN and clk_out[k] constantly 0.
REQ-024 div_r[k] == 0: the channel is disabled; ce[k] = clk_out[k] = 0 and cnt[k] is held at 0.
REQ-025 Channels SHALL be mutually independent; channels with equal div_r and phase_r SHALL produce identical, cycle-aligned outputs.
REQ-026 Counters SHALL be CNT_W bits unsigned; the compare against div_r-1 SHALL not overflow for div_r = 2^CNT_W-1.
REQ-027 All outputs SHALL be driven directly from flops; no combinational path from inputs to outputs.

Reset
REQ-028 areset=1 SHALL, asynchronously, force WAIT, lock_cnt=0, locked=0, clk_out=0, ce=0, cnt=0, div_r=DEF_DIV and phase_r=0 for all channels.
REQ-029 areset asserted mid-RUN SHALL drop all outputs immediately, with no glitch beyond the reset edge; after release, lock follows REQ-015 using the DEF_DIV configuration.
REQ-030 cfg_load while areset=1 SHALL be ignored.

Verification
REQ-031 Power-up: areset high for 100 cycles, then released with defaults -> locked rises at edge 16 after release; each clk_out toggles every cycle (div 2) and ce pulses every 2 cycles, with all channels aligned.
REQ-032 Divide sweep: cfg_load with div={5,4,1,0} and phase 0 -> locked drops, relocks after 16 cycles:
  - ch0 period 5, high 2 cycles
  - ch1 period 4, high 2 cycles
  - ch2 ce constantly 1, clk_out 0
  - ch3 all 0
REQ-033 Phase: div={8,8,8,8}, phase={0,2,4,9} -> ch1/ch2 ce pulses lead ch0 by 2/4 cycles; ch3 (phase >= div) is aligned with ch0.
REQ-034 Back-to-back load: cfg_load at WAIT cycle 10, then again at cycle 3 of the new count -> locked rises 16 cycles after the second load, using the second configuration.
REQ-035 Reset mid-run: areset pulsed for 1 ns asynchronously during RUN with div=7 -> outputs 0 immediately; after release, relock in 16 cycles with div=2 defaults.
REQ-036 Wide count: CNT_W=16, div=65535 -> exactly one ce pulse per 65535 cycles over 3 periods, with no wrap error.
